vc_rr_lock_arb: RTL and testbench
=================================

Name: vc_rr_lock_arb

Overview:
- Stateful round-robin arbiter for the ring-network router output ports.
- Wraps a variable-priority kill-chain core with three registered pieces of state:
  - a one-hot priority pointer that rotates past each winner;
  - a grant lock that holds the output for multi-flit packets;
  - a registered security domain that flushes arbitration state on a domain switch.
- Sits between the input-queue request vectors and the crossbar select logic.

Parameters:
- p_num_reqs, 4, number of requesters (>=1).
- p_idx_bits, (p_num_reqs>1 ? $clog2(p_num_reqs) : 1), width of the binary grant index (derived; do not override).
- p_reset_prio, 1, one-hot priority value loaded on reset and on domain switch (bit 0 = requester 0 highest).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- domain  in  1  security domain of the current cycle; label L.
- en  in  1  state update enable; when 0, all registers hold. Label Domain domain, as are all following ports.
- kin  in  1  kill in; when 1, forces grants to 0.
- reqs  in  p_num_reqs  1 = requesting.
- hold  in  1  winner keeps the grant next cycle (packet not at tail flit).
- grants  out  p_num_reqs  one-hot grant, or all-zero.
- grant_idx  out  p_idx_bits  binary index of the granted requester; 0 when no grant.
- grant_val  out  1  |grants.
- kout  out  1  kin OR grant_val.
- locked  out  1  registered lock flag.

Behaviour:
- Reset (reset==0, asynchronous):
  - prio_reg=p_reset_prio, lock_reg=0, lock_idx=0, domain_reg=0.
  - Outputs follow combinationally from these values; locked=0.
- Domain switch (dsw = domain != domain_reg):
  - Combinational path uses eff_prio=p_reset_prio and eff_lock=0.
  - Otherwise eff_prio=prio_reg and eff_lock=lock_reg.
  - Grants therefore never depend on state built up in another domain.
- Grant logic (combinational, zero latency):
  - kin=1 -> grants=0.
  - Else eff_lock=1 and reqs[lock_idx]=1 -> grants=onehot(lock_idx); all other requesters ignored.
  - Else grants = variable-priority chain result of (eff_prio, reqs): the first requester at or after the priority bit, wrapping from p_num_reqs-1 to 0.
  - If nothing is requested, grants=0.
- Register update, on posedge clk when en=1, in priority order:
  1. dsw=1: domain_reg<=domain, prio_reg<=p_reset_prio, lock_reg<=0. This overrides all other updates.
  2. grant_val=1: prio_reg <= grants rotated left by 1 (bit N-1 wraps to bit 0); lock_reg<=hold; lock_idx<=grant_idx.
  3. grant_val=0 (no request, or kin=1): prio_reg holds; lock_reg<=lock_reg & reqs[lock_idx]. A locked requester that drops its request releases the lock.
- en=0: all registers hold, including domain_reg. grants is still computed combinationally.
- Pointer behaviour under lock:
  - While locked, prio_reg is rewritten each cycle to onehot(lock_idx+1 mod N), so release resumes fairly after the lock holder.
  - A held grant under kin=1 does not advance or break the lock.
- p_num_reqs=1:
  - grants = reqs & ~kin; grant_idx=0.
  - prio_reg is constant 1; lock logic still tracks hold.
- Invariants (verification asserts):
  - grants is one-hot or zero.
  - grants ⊆ reqs.
  - prio_reg is always one-hot.
  - grant_idx is consistent with grants.

Decomposition:
- Package vc_arb_pkg holds:
  - the onehot-to-index function (p_idx_bits wide);
  - the rotate-left-by-one function;
  - the lock/priority state struct typedef.
- One sub-module: reuse vc_VariableArbChain as the combinational core, fed eff_prio, reqs and kin=0.
- The kin, lock and domain muxing live in vc_rr_lock_arb itself.

Test Plan:
1. Reset mid-operation: assert reset=0 with reqs=4'b1111, then release -> grants=4'b0001 and locked=0 in the same cycle, regardless of prior state.
2. Fairness: reqs=4'b1111 with hold=0, en=1 for 8 cycles -> grants sequence 0001,0010,0100,1000,0001,0010,0100,1000.
3. Lock: reqs=4'b0110, hold=1 for 3 cycles then hold=0 -> grants=0010 for 4 cycles, then 0100; locked=1 during cycles 2-4.
4. Lock release by drop: locked on requester 2, then reqs changes to 4'b1001 -> lock clears; grants=1000 (pointer at 3); next cycle grants=0001.
5. kin and en: kin=1 with reqs=4'b1111 -> grants=0 and kout=1, prio_reg unchanged. With en=0 and kin=0 for 3 cycles -> grants stays 0001 each cycle.
6. Domain switch: with prio_reg=0100 and lock_reg=1, toggle domain while reqs=4'b1100 -> same-cycle grants=0100 (computed from reset priority); next state prio_reg=0001, lock_reg=0.

Source files
------------

// File: rtl/vc_arb_pkg.sv
// Shared helpers and state types for the round-robin lock arbiter.
// The helpers work on vectors up to MAX_REQS wide; callers size-cast in and out.
package vc_arb_pkg;

    localparam int unsigned MAX_REQS     = 32;
    localparam int unsigned MAX_IDX_BITS = 5;

    // Lock and domain flags that sit beside the priority pointer.
    typedef struct packed {
        logic lock;
        logic domain;
    } arb_state_t;

    function automatic logic [MAX_IDX_BITS-1:0] onehot_to_idx(input logic [MAX_REQS-1:0] vec);
        logic [MAX_IDX_BITS-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQS; i++) begin
            if (vec[MAX_IDX_BITS'(i)]) idx |= MAX_IDX_BITS'(i);
        end
        return idx;
    endfunction

    // Rotate the low n bits left by one; bit n-1 wraps to bit 0.
    function automatic logic [MAX_REQS-1:0] rotl1(input logic [MAX_REQS-1:0] vec,
                                                  input int unsigned      n);
        logic [MAX_REQS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQS; i++) begin
            if (i < n) r[MAX_IDX_BITS'((i + 1) % n)] = vec[MAX_IDX_BITS'(i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/vc_VariableArbChain.sv
// Combinational variable-priority kill-chain arbiter.
// The chain is unrolled twice so the search wraps from the last requester back to 0.
module vc_VariableArbChain #(
    parameter int unsigned p_num_reqs = 4
)(
    input  logic                  kin,
    input  logic [p_num_reqs-1:0] prio,
    input  logic [p_num_reqs-1:0] reqs,
    output logic [p_num_reqs-1:0] grants
);

    logic [2*p_num_reqs-1:0] carry;
    logic [2*p_num_reqs-1:0] pass_grants;

    // Everything before the first priority bit is killed; the chain restarts at the priority bit.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < 2*p_num_reqs; i++) begin : g_chain
        localparam int unsigned K = i % p_num_reqs;
        logic kill;
        assign kill           = prio[K] ? kin : carry[i];
        assign pass_grants[i] = reqs[K] & ~kill;
        if (i < 2*p_num_reqs-1) begin : g_carry
            assign carry[i+1] = kill | reqs[K];
        end
    end

    for (genvar k = 0; k < p_num_reqs; k++) begin : g_merge
        assign grants[k] = pass_grants[k] | pass_grants[k+p_num_reqs];
    end

endmodule

// File: rtl/vc_rr_lock_arb.sv
// Round-robin arbiter with packet grant lock and security-domain flush.
// Supports up to 32 requesters (width of the package helpers).
module vc_rr_lock_arb
    import vc_arb_pkg::*;
#(
    parameter int unsigned           p_num_reqs   = 4,
    parameter int unsigned           p_idx_bits   = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1,
    parameter logic [p_num_reqs-1:0] p_reset_prio = p_num_reqs'(1)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  domain,
    input  logic                  en,
    input  logic                  kin,
    input  logic [p_num_reqs-1:0] reqs,
    input  logic                  hold,
    output logic [p_num_reqs-1:0] grants,
    output logic [p_idx_bits-1:0] grant_idx,
    output logic                  grant_val,
    output logic                  kout,
    output logic                  locked
);

    arb_state_t            state;
    logic [p_num_reqs-1:0] prio_reg;
    logic [p_idx_bits-1:0] lock_idx;

    logic                  dsw;
    logic                  eff_lock;
    logic                  lock_hit;
    logic [p_num_reqs-1:0] eff_prio;
    logic [p_num_reqs-1:0] chain_grants;
    logic [p_num_reqs-1:0] lock_onehot;

    // A domain switch hides all state built up in the previous domain in the same cycle.
    assign dsw = domain != state.domain;

    always_comb begin
        eff_prio = prio_reg;
        eff_lock = state.lock;
        if (dsw) begin
            eff_prio = p_reset_prio;
            eff_lock = 1'b0;
        end
    end

    vc_VariableArbChain #(
        .p_num_reqs (p_num_reqs)
    ) u_chain (
        .kin    (1'b0),
        .prio   (eff_prio),
        .reqs   (reqs),
        .grants (chain_grants)
    );

    assign lock_onehot = p_num_reqs'(1) << lock_idx;
    assign lock_hit    = eff_lock & reqs[lock_idx];

    always_comb begin
        grants = '0;
        if (!kin) grants = lock_hit ? lock_onehot : chain_grants;
    end

    assign grant_idx = p_idx_bits'(onehot_to_idx(MAX_REQS'(grants)));
    assign grant_val = |grants;
    assign kout      = kin | grant_val;
    assign locked    = state.lock;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_reg <= p_reset_prio;
            lock_idx <= '0;
            state    <= '0;
        end else if (en) begin
            if (dsw) begin
                state.domain <= domain;
                state.lock   <= 1'b0;
                prio_reg     <= p_reset_prio;
            end else if (grant_val) begin
                prio_reg   <= p_num_reqs'(rotl1(MAX_REQS'(grants), p_num_reqs));
                state.lock <= hold;
                lock_idx   <= grant_idx;
            end else begin
                // Killed or idle cycle: the lock survives only while its owner keeps requesting.
                state.lock <= state.lock & reqs[lock_idx];
            end
        end
    end

endmodule

// File: tb/tb_vc_rr_lock_arb.sv
// Directed bench for vc_rr_lock_arb: literal expectations plus a per-cycle reference model.
module tb_vc_rr_lock_arb;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         domain;
    logic         en;
    logic         kin;
    logic         hold;
    logic [N-1:0] reqs;
    logic [N-1:0] grants;
    logic [1:0]   grant_idx;
    logic         grant_val;
    logic         kout;
    logic         locked;

    int checks = 0;
    int passes = 0;

    // Reference state: pointer index, lock flag/owner, registered domain.
    int m_ptr  = 0;
    int m_lidx = 0;
    bit m_lock = 1'b0;
    bit m_dom  = 1'b0;

    always #5 clk = ~clk;

    vc_rr_lock_arb #(
        .p_num_reqs (N)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .domain    (domain),
        .en        (en),
        .kin       (kin),
        .reqs      (reqs),
        .hold      (hold),
        .grants    (grants),
        .grant_idx (grant_idx),
        .grant_val (grant_val),
        .kout      (kout),
        .locked    (locked)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    function automatic bit req_bit(input int j);
        return ((int'(reqs) >> j) & 1) != 0;
    endfunction

    // Winner index from the arbitration rules, or -1 for no grant.
    function automatic int model_winner();
        bit dsw;
        int ep;
        bit el;
        dsw = (domain != m_dom);
        ep  = dsw ? 0 : m_ptr;
        el  = dsw ? 1'b0 : m_lock;
        if (kin) return -1;
        if (el && req_bit(m_lidx)) return m_lidx;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ep + k) % N;
            if (req_bit(j)) return j;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            int win;
            @(negedge clk);
            #4;
            if (!rst) begin
                m_ptr  = 0;
                m_lock = 1'b0;
                m_lidx = 0;
                m_dom  = 1'b0;
            end
            win = model_winner();
            chk("m_grants", 32'(grants), (win < 0) ? 32'd0 : (32'd1 << win));
            chk("m_grant_idx", 32'(grant_idx), (win < 0) ? 32'd0 : 32'(win));
            chk("m_grant_val", 32'(grant_val), (win < 0) ? 32'd0 : 32'd1);
            chk("m_kout", 32'(kout), (kin || win >= 0) ? 32'd1 : 32'd0);
            chk("m_locked", 32'(locked), 32'(m_lock));
            if (rst && en) begin
                if (domain != m_dom) begin
                    m_dom  = domain;
                    m_ptr  = 0;
                    m_lock = 1'b0;
                end else if (win >= 0) begin
                    m_ptr  = (win + 1) % N;
                    m_lock = hold;
                    m_lidx = win;
                end else begin
                    m_lock = m_lock && req_bit(m_lidx);
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic h, input logic k, input logic e,
                        input logic d, input logic rs, input bit lit,
                        input logic [N-1:0] lg, input logic ll, input string tag);
        @(negedge clk);
        reqs   = r;
        hold   = h;
        kin    = k;
        en     = e;
        domain = d;
        rst    = rs;
        #4;
        if (lit) begin
            chk({tag, "_grants"}, 32'(grants), 32'(lg));
            chk({tag, "_locked"}, 32'(locked), 32'(ll));
        end
    endtask

    initial begin
        rst = 1'b0; reqs = 4'b1111; hold = 1'b0; kin = 1'b0; en = 1'b1; domain = 1'b0;

        step(4'b1111, 0, 0, 1, 0, 0, 1, 4'b0001, 0, "reset_a");
        step(4'b1111, 0, 0, 1, 0, 0, 1, 4'b0001, 0, "reset_b");

        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] exp_g;
            exp_g = 4'b0001 << (i % 4);
            step(4'b1111, 0, 0, 1, 0, 1, 1, exp_g, 0, "fair");
        end

        step(4'b0110, 1, 0, 1, 0, 1, 1, 4'b0010, 0, "lock1");
        step(4'b0110, 1, 0, 1, 0, 1, 1, 4'b0010, 1, "lock2");
        step(4'b0110, 1, 0, 1, 0, 1, 1, 4'b0010, 1, "lock3");
        step(4'b0110, 0, 0, 1, 0, 1, 1, 4'b0010, 1, "lock4");
        step(4'b0110, 0, 0, 1, 0, 1, 1, 4'b0100, 0, "lock5");

        step(4'b0100, 1, 0, 1, 0, 1, 1, 4'b0100, 0, "drop_a");
        step(4'b1001, 0, 0, 1, 0, 1, 1, 4'b1000, 1, "drop_b");
        step(4'b1001, 0, 0, 1, 0, 1, 1, 4'b0001, 0, "drop_c");

        step(4'b1111, 0, 1, 1, 0, 1, 1, 4'b0000, 0, "kin");
        chk("kin_kout", 32'(kout), 32'd1);
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0010, 0, "kin_after");
        step(4'b1000, 0, 0, 1, 0, 1, 1, 4'b1000, 0, "to_p0");
        for (int i = 0; i < 3; i++) step(4'b1111, 0, 0, 0, 0, 1, 1, 4'b0001, 0, "en0");
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0001, 0, "en1");
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0010, 0, "en1b");

        step(4'b0100, 1, 0, 1, 0, 1, 1, 4'b0100, 0, "klock_a");
        step(4'b0100, 1, 1, 1, 0, 1, 1, 4'b0000, 1, "klock_kin");
        chk("klock_kout", 32'(kout), 32'd1);
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0100, 1, "klock_b");

        step(4'b0010, 1, 0, 1, 0, 1, 1, 4'b0010, 0, "dsw_setup");
        step(4'b1100, 0, 0, 1, 1, 1, 1, 4'b0100, 1, "dsw");
        step(4'b1111, 0, 0, 1, 1, 1, 1, 4'b0001, 0, "dsw_after");
        step(4'b1111, 0, 0, 0, 0, 1, 1, 4'b0001, 0, "dsw_en0");
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0001, 0, "dsw_en1");
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0001, 0, "dsw_settle");

        step(4'b1010, 0, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b0101, 1, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b0101, 1, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b0011, 0, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b1110, 0, 1, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b1110, 0, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b0001, 1, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b0000, 0, 0, 1, 0, 1, 0, '0, 0, "mix");
        step(4'b1111, 0, 0, 1, 1, 1, 0, '0, 0, "mix");
        step(4'b1111, 1, 0, 1, 1, 1, 0, '0, 0, "mix");

        step(4'b0100, 1, 0, 1, 1, 1, 0, '0, 0, "pre_rst");
        step(4'b0100, 1, 0, 1, 1, 1, 0, '0, 0, "pre_rst");
        step(4'b1111, 0, 0, 1, 0, 0, 1, 4'b0001, 0, "rst_mid");
        step(4'b1111, 0, 0, 1, 0, 1, 1, 4'b0001, 0, "rst_rel");

        @(negedge clk);
        #6;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
